// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared opcode encodings, FSM states and cycle defaults for the MDU
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // True for the opcodes that occupy the unit for more than one cycle.
  function automatic logic is_multicycle(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide datapath
// Ports:
//   a, b   : 32-bit operands (rs, rt)
//   op     : MDU opcode
//   result : MULT/MULTU -> 64-bit product; DIV/DIVU -> {remainder, quotient}; else 0
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [63:0] result
);

  logic        sgn_mul;
  logic        sgn_div;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    sgn_mul = (op == OP_MULT);
    sgn_div = (op == OP_DIV);

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    ext_a = {{32{sgn_mul & a[31]}}, a};
    ext_b = {{32{sgn_mul & b[31]}}, b};
    prod  = ext_a * ext_b;

    // Signed division is done on magnitudes so that 0x80000000 / -1 simply
    // wraps to 0x80000000 with remainder 0 instead of overflowing.
    a_neg = sgn_div & a[31];
    b_neg = sgn_div & b[31];
    a_mag = a_neg ? (32'd0 - a) : a;
    b_mag = b_neg ? (32'd0 - b) : b;
    if (b_mag == 32'd0) begin
      q_mag = 32'd0;
      r_mag = 32'd0;
    end else begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem  = a_neg ? (32'd0 - r_mag) : r_mag;

    result = 64'd0;
    if ((op == OP_MULT) || (op == OP_MULTU)) begin
      result = prod;
    end else if ((op == OP_DIV) || (op == OP_DIVU)) begin
      result = {rem, quot};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit control: FSM, latency counter, HI/LO registers
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   start, op  : E-stage MDU instruction valid and its opcode
//   a, b       : rs / rt operands, sampled only on the start edge
//   md_in_d    : decode stage holds an MDU instruction
//   rd_hi      : rd_data select (1 = HI, 0 = LO)
//   busy       : multi-cycle operation in flight
//   stall      : decode-stage stall request
//   hi, lo     : committed HI/LO registers
//   rd_data    : selected committed register
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_in_d,
  input  logic        rd_hi,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  mdu_state_e  state;
  logic [3:0]  cnt;
  logic [31:0] ph;
  logic [31:0] pl;
  logic [63:0] arith_res;

  mdu_arith u_arith (
    .a      (a),
    .b      (b),
    .op     (op),
    .result (arith_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      ph    <= 32'd0;
      pl    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                {ph, pl} <= arith_res;
                cnt      <= 4'(MULT_CYCLES);
                state    <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                // A zero divisor still burns the full latency; pending is
                // loaded with the current HI/LO so the commit is a no-op.
                if (b == 32'd0) begin
                  {ph, pl} <= {hi, lo};
                end else begin
                  {ph, pl} <= arith_res;
                end
                cnt   <= 4'(DIV_CYCLES);
                state <= ST_RUN;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            hi    <= ph;
            lo    <= pl;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state == ST_RUN);
  assign stall   = md_in_d & (busy | (start & is_multicycle(op)));
  assign rd_data = rd_hi ? hi : lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl with a behavioural HI/LO model
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_in_d;
  logic        rd_hi;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int total;
  int bad;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .md_in_d (md_in_d),
    .rd_hi   (rd_hi),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one operation on HI/LO, from plain arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;
    logic [63:0] p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (o)
      3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'd0, av} * {32'd0, bv}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: if (bv != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        m_lo = sq[31:0];
        m_hi = sr[31:0];
      end
      3'd3: if (bv != 0) begin
        m_lo = av / bv;
        m_hi = av % bv;
      end
      3'd4: m_hi = av;
      3'd5: m_lo = av;
      default: ;
    endcase
  endtask

  // Multi-cycle op: checks stall/busy each cycle, old values on rd_data, then commit.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input bit scramble);
    int          n;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    n      = (o < 3'd2) ? 5 : 10;
    old_hi = m_hi;
    old_lo = m_lo;
    op = o; a = av; b = bv; start = 1'b1;
    #1;
    chk("stall_start", {31'd0, stall}, {31'd0, md_in_d});
    tick();
    start = 1'b0;
    if (scramble) begin
      a  = $urandom;
      b  = $urandom;
      op = 3'($urandom_range(0, 7));
    end
    for (int i = 1; i <= n; i++) begin
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("stall_run", {31'd0, stall}, {31'd0, md_in_d});
      rd_hi = i[0];
      #1;
      chk("rd_pending", rd_data, rd_hi ? old_hi : old_lo);
      tick();
    end
    model(o, av, bv);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("hi_commit", hi, m_hi);
    chk("lo_commit", lo, m_lo);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    total = 0; bad = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    md_in_d = 1'b0; rd_hi = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // MULT -2 * 3 with an MDU instruction waiting in decode
    md_in_d = 1'b1;
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("stall_after", {31'd0, stall}, 32'd0);
    md_in_d = 1'b0;

    run_op(3'd3, 32'd7, 32'd2, 1'b1);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // Divide by zero keeps HI/LO
    start = 1'b1; op = 3'd4; a = 32'h11; tick();
    op = 3'd5; a = 32'h22; tick();
    start = 1'b0;
    model(3'd4, 32'h11, 32'd0);
    model(3'd5, 32'h22, 32'd0);
    run_op(3'd2, 32'd5, 32'd0, 1'b1);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    // MTHI single cycle, no busy
    md_in_d = 1'b1;
    start = 1'b1; op = 3'd4; a = 32'hABCD;
    #1;
    chk("mthi_stall", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0; md_in_d = 1'b0;
    model(3'd4, 32'hABCD, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'hABCD);
    rd_hi = 1'b1; #1;
    chk("rd_hi_sel", rd_data, 32'hABCD);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // Reset in the middle of a DIV
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd9; tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("abort_nocommit_hi", hi, 32'd0);
    chk("abort_nocommit_lo", lo, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // MULT arriving while a DIV runs is ignored
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7; tick();
    start = 1'b0;
    tick();
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3; tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("ign_busy_t10", {31'd0, busy}, 32'd1);
    tick();
    model(3'd2, 32'd100, 32'd7);
    chk("ign_busy_t11", {31'd0, busy}, 32'd0);
    chk("ign_lo", lo, 32'd14);
    chk("ign_hi", hi, 32'd2);
    tick();
    chk("ign_no_second", {31'd0, busy}, 32'd0);
    chk("ign_hi_keep", hi, m_hi);

    // Random mix
    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      md_in_d = 1'($urandom_range(0, 1));
      if (ro < 3'd4) begin
        run_op(ro, ra, rb, 1'b1);
      end else begin
        start = 1'b1; op = ro; a = ra; b = rb;
        #1;
        chk("rnd_stall_single", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0;
        model(ro, ra, rb);
        chk("rnd_busy_single", {31'd0, busy}, 32'd0);
        chk("rnd_hi", hi, m_hi);
        chk("rnd_lo", lo, m_lo);
      end
      rd_hi = 1'b0; #1;
      chk("rnd_rd_lo", rd_data, m_lo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy duration of MULT/MULTU in cycles (legal 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy duration of DIV/DIVU in cycles (legal 1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage MDU instruction valid this cycle.
REQ-006 op  input  3  MDU opcode; encodings per REQ-040.
REQ-007 a  input  32  rs operand.
REQ-008 b  input  32  rt operand.
REQ-009 md_in_d  input  1  decode stage holds any MDU instruction (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 rd_hi  input  1  read select: 1 = HI, 0 = LO.
REQ-011 busy  output  1  multi-cycle operation in progress.
REQ-012 stall  output  1  pipeline stall request for decode stage.
REQ-013 hi  output  32  architectural HI register.
REQ-014 lo  output  32  architectural LO register.
REQ-015 rd_data  output  32  rd_hi ? hi : lo, combinational.

Function
REQ-016 SHALL implement FSM states IDLE and RUN with a 4-bit down-counter cnt.
REQ-017 IDLE, start=1, op MULT/MULTU: SHALL latch the 64-bit product into pending {ph,pl}, load cnt=MULT_CYCLES, go RUN.
REQ-018 IDLE, start=1, op DIV/DIVU: SHALL latch quotient into pl and remainder into ph, load cnt=DIV_CYCLES, go RUN.
REQ-019 RUN: cnt SHALL decrement each cycle; on the edge where cnt==1, hi<=ph, lo<=pl, go IDLE.
REQ-020 busy SHALL equal (state==RUN); start at cycle T gives busy=1 for T+1..T+N and new hi/lo visible from T+N+1.
REQ-021 Operands SHALL be sampled only at the start cycle; later changes on a/b have no effect.
REQ-022 MULT/DIV SHALL be two's-complement signed; MULTU/DIVU unsigned; division truncates toward zero, remainder takes sign of dividend.
REQ-023 Divide by zero SHALL still take DIV_CYCLES but leave hi and lo unchanged.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0.
REQ-025 MTHI/MTLO with start=1 in IDLE SHALL write a to hi/lo on that edge, single cycle, busy stays 0.
REQ-026 start=1 while RUN SHALL be ignored (no state, counter or register change).
REQ-027 Undefined op codes with start=1 SHALL be no-ops.
REQ-028 stall SHALL equal md_in_d & (busy | (start & op in {MULT,MULTU,DIV,DIVU})), combinational.
REQ-029 rd_data SHALL reflect committed hi/lo only, never pending values.

Reset
REQ-030 reset low SHALL immediately force state=IDLE, cnt=0, hi=lo=ph=pl=0, busy=0.
REQ-031 Reset asserted mid-RUN SHALL abort the operation with no commit; first start after release behaves as from IDLE.
REQ-032 stall after reset SHALL depend only on md_in_d, start and op per REQ-028.

Structure
REQ-040 Shared package mdu_pkg SHALL hold op encodings MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5 and default cycle constants.
REQ-041 Combinational arithmetic SHALL reside in sub-module mdu_arith (a, b, op -> 64-bit result); mdu_ctrl holds the FSM, counter and registers.

Verification
REQ-050 MULT a=0xFFFFFFFE(-2), b=3 at T -> busy 1 for T+1..T+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA at T+6.
REQ-051 DIVU a=7, b=2 -> after 10 busy cycles lo=3, hi=1; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-052 DIV a=5, b=0 with hi=0x11, lo=0x22 -> 10 busy cycles, hi=0x11, lo=0x22 unchanged.
REQ-053 md_in_d=1 held during MULT -> stall=1 at start cycle T and T+1..T+5, 0 at T+6; MTHI a=0xABCD in IDLE -> hi=0xABCD next cycle, busy never 1.
REQ-054 Reset pulsed low at T+3 of a DIV -> busy=0, hi=lo=0 immediately; no commit at T+10.
REQ-055 start with MULT at T+2 during a DIV -> ignored; DIV result commits at T+11, busy drops, no second operation.
